// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory access unit.
//   - default widths (byte address, log2 bytes per word, word width)
//   - access size encoding seen on req_size
//   - FSM state encoding used by dmem_access_unit
package dmem_pkg;

    localparam int DMEMADDRBITS_DEF = 13;
    localparam int DMEMWORDBITS_DEF = 2;
    localparam int DBITS_DEF        = 8 << DMEMWORDBITS_DEF;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_e;

endpackage

// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: CPU-side request/response bus of the access unit.
//   req_valid/req_ready  : request handshake
//   req_we/size/signed   : access kind (size encoded as dmem_pkg::size_e)
//   req_addr/req_wdata   : byte address, right-aligned store data
//   resp_valid           : one-cycle completion pulse
//   resp_rdata/resp_err  : load result / misaligned-or-illegal flag
// modport master = CPU side, modport slave = access unit.
interface dmem_access_unit_if
    import dmem_pkg::*;
#(
    parameter int DMEMADDRBITS = DMEMADDRBITS_DEF,
    parameter int DBITS        = DBITS_DEF
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [1:0]              req_size;
    logic                    req_signed;
    logic [DMEMADDRBITS-1:0] req_addr;
    logic [DBITS-1:0]        req_wdata;
    logic                    resp_valid;
    logic [DBITS-1:0]        resp_rdata;
    logic                    resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational little-endian lane handling.
//   size/sgn/off : latched access size, sign-extend flag, byte offset in word
//   word         : word read from memory
//   wdata        : right-aligned store data
//   rdata        : extracted lane(s), zero- or sign-extended
//   merged       : word with the addressed lane(s) replaced by wdata
// Word accesses pass through (rdata = word, merged = wdata).
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DMEMWORDBITS = DMEMWORDBITS_DEF,
    parameter int DBITS        = 8 << DMEMWORDBITS
) (
    input  size_e                   size,
    input  logic                    sgn,
    input  logic [DMEMWORDBITS-1:0] off,
    input  logic [DBITS-1:0]        word,
    input  logic [DBITS-1:0]        wdata,
    output logic [DBITS-1:0]        rdata,
    output logic [DBITS-1:0]        merged
);
    // Half index drops the byte-within-half bit.
    logic [DMEMWORDBITS-2:0] hoff;
    logic [7:0]              b;
    logic [15:0]             h;

    assign hoff = off[DMEMWORDBITS-1:1];
    assign b    = word[{off, 3'b000} +: 8];
    assign h    = word[{hoff, 4'b0000} +: 16];

    always_comb begin
        rdata  = word;
        merged = wdata;
        case (size)
            SZ_BYTE: begin
                rdata  = {{(DBITS-8){sgn & b[7]}}, b};
                merged = word;
                merged[{off, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                rdata  = {{(DBITS-16){sgn & h[15]}}, h};
                merged = word;
                merged[{hoff, 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: serialises CPU loads/stores onto a single-port word
// memory that samples on negedge. One request outstanding at a time.
//   clk, reset    : single clock, synchronous active-high reset
//   bus (slave)   : CPU request/response, see dmem_access_unit_if
//   mem_wrtEn     : memory write enable (only in WR, never while reset)
//   mem_addr      : word address of the latched request
//   mem_in        : write data (merged word for sub-word stores)
//   mem_out       : read data, valid at the posedge ending RD
// Build option: DMEM_SUBWORD_EN enables byte/half accesses (RMW stores,
// lane extract). Without it only aligned word accesses are legal.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int DMEMADDRBITS = DMEMADDRBITS_DEF,
    parameter int DMEMWORDBITS = DMEMWORDBITS_DEF,
    parameter int DBITS        = 8 << DMEMWORDBITS
) (
    input  logic                                 clk,
    input  logic                                 reset,
    dmem_access_unit_if.slave                    bus,
    output logic                                 mem_wrtEn,
    output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_addr,
    output logic [DBITS-1:0]                     mem_in,
    input  logic [DBITS-1:0]                     mem_out
);
    localparam int WA = DMEMADDRBITS - DMEMWORDBITS;

    state_e                  state_q, state_d;
    logic                    we_q, err_q;
    logic [WA-1:0]           wa_q;
    logic [DBITS-1:0]        wdata_q, word_q;
    logic [DBITS-1:0]        rdata_ext, merged;
`ifdef DMEM_SUBWORD_EN
    size_e                   size_q;
    logic                    sgn_q;
    logic [DMEMWORDBITS-1:0] off_q;
`endif

    size_e                   req_size;
    logic [DMEMWORDBITS-1:0] req_off;
    logic                    req_err;
    logic                    accept;

    assign req_size = size_e'(bus.req_size);
    assign req_off  = bus.req_addr[DMEMWORDBITS-1:0];
    assign accept   = bus.req_valid && bus.req_ready;

    always_comb begin
        req_err = 1'b0;
`ifdef DMEM_SUBWORD_EN
        case (req_size)
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = req_off[0];
            SZ_WORD: req_err = (req_off != '0);
            default: req_err = 1'b1;
        endcase
`else
        req_err = (req_size != SZ_WORD) || (req_off != '0);
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_err)
                        state_d = RESP;
                    // Loads and sub-word stores both need the current word first.
                    else if (!bus.req_we || req_size != SZ_WORD)
                        state_d = RD;
                    else
                        state_d = WR;
                end
            end
`ifdef DMEM_SUBWORD_EN
            RD:      state_d = we_q ? WR : RESP;
`else
            RD:      state_d = RESP;
`endif
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            wa_q    <= '0;
            wdata_q <= '0;
            word_q  <= '0;
`ifdef DMEM_SUBWORD_EN
            size_q  <= SZ_WORD;
            sgn_q   <= 1'b0;
            off_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= bus.req_we;
                err_q   <= req_err;
                wa_q    <= bus.req_addr[DMEMADDRBITS-1:DMEMWORDBITS];
                wdata_q <= bus.req_wdata;
`ifdef DMEM_SUBWORD_EN
                size_q  <= req_size;
                sgn_q   <= bus.req_signed;
                off_q   <= req_off;
`endif
            end
            if (state_q == RD)
                word_q <= mem_out;
        end
    end

`ifdef DMEM_SUBWORD_EN
    dmem_lane_align #(
        .DMEMWORDBITS(DMEMWORDBITS),
        .DBITS       (DBITS)
    ) u_align (
        .size  (size_q),
        .sgn   (sgn_q),
        .off   (off_q),
        .word  (word_q),
        .wdata (wdata_q),
        .rdata (rdata_ext),
        .merged(merged)
    );
`else
    assign rdata_ext = word_q;
    assign merged    = wdata_q;
`endif

    assign bus.req_ready  = (state_q == IDLE) && !reset;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_err   = (state_q == RESP) && err_q;
    assign bus.resp_rdata = (state_q == RESP && !we_q && !err_q) ? rdata_ext : '0;

    // Reset gates the strobe combinationally so an RMW cut short never writes.
    assign mem_wrtEn = (state_q == WR) && !reset;
    assign mem_addr  = wa_q;
    assign mem_in    = (state_q == WR) ? merged : '0;
endmodule
